// File: rtl/regfile_write_sequencer.sv
// Write-port owner for the 32x32 register file. After reset it zeroes x1..x31,
// then grants round-robin among NUM_REQ writeback requesters and registers the winner.
module regfile_write_sequencer #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      hold,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rf_w_enable,
  output logic [ADDR_W-1:0]         rf_data_addr,
  output logic [DATA_W-1:0]         rf_data_in,
  output logic                      init_done
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic {S_INIT, S_ARB} state_t;

  state_t                         state_q;
  logic [ADDR_W-1:0]              init_cnt_q;
  logic [PTR_W-1:0]               rr_ptr_q, rr_ptr_d, gnt_idx;
  logic                           rf_w_enable_q, init_done_q;
  logic [ADDR_W-1:0]              rf_data_addr_q;
  logic [DATA_W-1:0]              rf_data_in_q;
  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_a;
  logic [NUM_REQ-1:0][DATA_W-1:0] data_a;
  logic                           accept;
  int                             idx;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i] = req_addr[i*ADDR_W +: ADDR_W];
    assign data_a[i] = req_data[i*DATA_W +: DATA_W];
  end

  // Scan from rr_ptr upward with wrap; the first valid requester wins.
  always_comb begin
    req_ready = '0;
    gnt_idx   = '0;
    accept    = 1'b0;
    idx       = 0;
    if (state_q == S_ARB && !hold) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!accept && req_valid[idx]) begin
          accept         = 1'b1;
          gnt_idx        = PTR_W'(idx);
          req_ready[idx] = 1'b1;
        end
      end
    end
    rr_ptr_d = (gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_INIT;
      init_cnt_q     <= ADDR_W'(1);
      rr_ptr_q       <= '0;
      rf_w_enable_q  <= 1'b0;
      rf_data_addr_q <= '0;
      rf_data_in_q   <= '0;
      init_done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          rf_w_enable_q  <= 1'b1;
          rf_data_addr_q <= init_cnt_q;
          rf_data_in_q   <= '0;
          init_cnt_q     <= init_cnt_q + 1'b1;
          if (init_cnt_q == LAST_ADDR) begin
            state_q     <= S_ARB;
            init_done_q <= 1'b1;
          end
        end
        S_ARB: begin
          // x0 writes still consume the grant and update addr/data, but never enable.
          rf_w_enable_q <= accept && (addr_a[gnt_idx] != '0);
          if (accept) begin
            rf_data_addr_q <= addr_a[gnt_idx];
            rf_data_in_q   <= data_a[gnt_idx];
            rr_ptr_q       <= rr_ptr_d;
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign rf_w_enable  = rf_w_enable_q;
  assign rf_data_addr = rf_data_addr_q;
  assign rf_data_in   = rf_data_in_q;
  assign init_done    = init_done_q;

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Randomized/directed bench for regfile_write_sequencer against a behavioural
// model: a count of init writes done, a round-robin pointer and the expected write.
module tb_regfile_write_sequencer;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int OW = AW + DW + 2;

  logic            clk = 1'b0;
  logic            reset, hold;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            rf_w_enable, init_done;
  logic [AW-1:0]   rf_data_addr;
  logic [DW-1:0]   rf_data_in;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int            m_ptr, m_writes;
  logic          m_we, m_done;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  regfile_write_sequencer #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .rf_w_enable(rf_w_enable),
    .rf_data_addr(rf_data_addr), .rf_data_in(rf_data_in), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_ptr = 0; m_writes = 0; m_we = 1'b0; m_done = 1'b0; m_addr = '0; m_data = '0;
  endtask

  // Requester to be granted under the current inputs, or -1.
  function automatic int model_grant();
    if (m_writes < 31 || hold) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_edge(input int g);
    if (m_writes < 31) begin
      m_writes++;
      m_we = 1'b1; m_addr = m_writes[AW-1:0]; m_data = '0;
    end else if (g >= 0) begin
      m_addr = req_addr[g*AW +: AW];
      m_data = req_data[g*DW +: DW];
      m_we   = (m_addr != 0);
      m_ptr  = (g + 1) % N;
    end else begin
      m_we = 1'b0;
    end
    m_done = (m_writes == 31);
  endtask

  // Advance one clock: returns observed/expected ready (before the edge) and outputs (after).
  task automatic run_cycle(output logic [N-1:0] rdy, output logic [N-1:0] erdy,
                           output logic [OW-1:0] obs, output logic [OW-1:0] exp);
    int g;
    #1;
    g    = model_grant();
    erdy = (g < 0) ? '0 : (N'(1) << g);
    rdy  = req_ready;
    @(posedge clk);
    model_edge(g);
    #1;
    obs = {rf_w_enable, init_done, rf_data_addr, rf_data_in};
    exp = {m_we, m_done, m_addr, m_data};
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic set_req(input logic [N-1:0] v);
    req_valid = v;
    for (int k = 0; k < N; k++) begin
      req_addr[k*AW +: AW] = AW'(5 + k);
      req_data[k*DW +: DW] = DW'(32'hA + k);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; hold = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({req_ready, rf_w_enable, init_done, rf_data_addr, rf_data_in} !== '0) begin
      fails++;
      $display("FAIL reset_state: got rdy=%b we=%b done=%b addr=%0d data=%h, want all zero",
               req_ready, rf_w_enable, init_done, rf_data_addr, rf_data_in);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_init();
    logic [N-1:0] r, er; logic [OW-1:0] o, e;
    for (int c = 1; c <= 34; c++) begin
      run_cycle(r, er, o, e);
      tests++;
      if ({r, o} !== {er, e}) begin
        fails++;
        $display("FAIL init c%0d: got rdy=%b out=%h, want rdy=%b out=%h", c, r, o, er, e);
      end
      if (c == 31) begin
        tests++;
        if ({rf_w_enable, init_done, rf_data_addr} !== {1'b1, 1'b1, 5'd31}) begin
          fails++;
          $display("FAIL init_last: got we=%b done=%b addr=%0d, want 1 1 31",
                   rf_w_enable, init_done, rf_data_addr);
        end
      end
    end
  endtask

  task automatic test_early_requests();
    logic [N-1:0] r, er; logic [OW-1:0] o, e;
    set_req('1);
    apply_reset();
    for (int c = 1; c <= 32; c++) begin
      run_cycle(r, er, o, e);
      tests++;
      if ({r, o} !== {er, e}) begin
        fails++;
        $display("FAIL early c%0d: got rdy=%b out=%h, want rdy=%b out=%h", c, r, o, er, e);
      end
      if (c == 32) begin
        tests++;
        if (r !== 3'b001) begin
          fails++;
          $display("FAIL early_first_grant: got rdy=%b, want 001", r);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] r, er; logic [OW-1:0] o, e;
    set_req('0);
    apply_reset();
    repeat (31) run_cycle(r, er, o, e);
    set_req('1);
    for (int c = 0; c < 6; c++) begin
      run_cycle(r, er, o, e);
      tests++;
      if ({r, o} !== {er, e} || !$onehot(r) || rf_data_addr !== AW'(5 + c % 3)
          || rf_data_in !== DW'(32'hA + c % 3) || rf_w_enable !== 1'b1) begin
        fails++;
        $display("FAIL round_robin c%0d: got rdy=%b we=%b addr=%0d data=%h, want rdy=%b we=1 addr=%0d data=%h",
                 c, r, rf_w_enable, rf_data_addr, rf_data_in, er, 5 + c % 3, 32'hA + c % 3);
      end
    end
  endtask

  task automatic test_ptr_wrap();
    logic [N-1:0] r, er; logic [OW-1:0] o, e;
    logic [N-1:0] want [3];
    logic [N-1:0] vin [3];
    want = '{3'b100, 3'b001, 3'b100};
    vin  = '{3'b100, 3'b101, 3'b101};
    for (int c = 0; c < 3; c++) begin
      req_valid = vin[c];
      run_cycle(r, er, o, e);
      tests++;
      if (r !== want[c] || {r, o} !== {er, e}) begin
        fails++;
        $display("FAIL ptr_wrap c%0d: got rdy=%b out=%h, want rdy=%b out=%h", c, r, o, want[c], e);
      end
    end
  endtask

  task automatic test_x0_discard();
    logic [N-1:0] r, er; logic [OW-1:0] o, e;
    req_valid = 3'b001;
    run_cycle(r, er, o, e);
    req_valid = 3'b010;
    req_addr[AW +: AW] = '0;
    req_data[DW +: DW] = 32'hDEADBEEF;
    run_cycle(r, er, o, e);
    tests++;
    if (r !== 3'b010 || rf_w_enable !== 1'b0 || rf_data_addr !== '0 || rf_data_in !== 32'hDEADBEEF
        || o !== e) begin
      fails++;
      $display("FAIL x0_discard: got rdy=%b we=%b addr=%0d data=%h, want rdy=010 we=0 addr=0 data=deadbeef",
               r, rf_w_enable, rf_data_addr, rf_data_in);
    end
    set_req('1);
    run_cycle(r, er, o, e);
    tests++;
    if (r !== 3'b100 || {r, o} !== {er, e}) begin
      fails++;
      $display("FAIL x0_ptr_advance: got rdy=%b, want 100", r);
    end
  endtask

  task automatic test_hold();
    logic [N-1:0] r, er; logic [OW-1:0] o, e;
    set_req('1);
    hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      run_cycle(r, er, o, e);
      tests++;
      if (r !== '0 || rf_w_enable !== 1'b0 || {r, o} !== {er, e}) begin
        fails++;
        $display("FAIL hold c%0d: got rdy=%b we=%b, want rdy=000 we=0", c, r, rf_w_enable);
      end
    end
    hold = 1'b0;
    run_cycle(r, er, o, e);
    tests++;
    if (r !== 3'b001 || {r, o} !== {er, e}) begin
      fails++;
      $display("FAIL hold_release: got rdy=%b out=%h, want rdy=001 out=%h", r, o, e);
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] r, er; logic [OW-1:0] o, e;
    set_req('1);
    repeat (3) run_cycle(r, er, o, e);
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if ({req_ready, rf_w_enable, init_done, rf_data_addr, rf_data_in} !== '0) begin
      fails++;
      $display("FAIL reset_mid_async: got rdy=%b we=%b done=%b addr=%0d data=%h, want all zero",
               req_ready, rf_w_enable, init_done, rf_data_addr, rf_data_in);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int c = 1; c <= 33; c++) begin
      run_cycle(r, er, o, e);
      tests++;
      if ({r, o} !== {er, e}) begin
        fails++;
        $display("FAIL reset_mid_reinit c%0d: got rdy=%b out=%h, want rdy=%b out=%h", c, r, o, er, e);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] r, er; logic [OW-1:0] o, e;
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      hold      = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < N; k++) begin
        req_addr[k*AW +: AW] = ($urandom_range(0, 4) == 0) ? '0 : AW'($urandom);
        req_data[k*DW +: DW] = $urandom;
      end
      run_cycle(r, er, o, e);
      tests++;
      if ({r, o} !== {er, e} || !$onehot0(r)) begin
        fails++;
        $display("FAIL random c%0d: got rdy=%b out=%h, want rdy=%b out=%h", c, r, o, er, e);
      end
    end
    hold = 1'b0;
  endtask

  initial begin
    test_reset();
    test_init();
    test_early_requests();
    test_round_robin();
    test_ptr_wrap();
    test_x0_discard();
    test_hold();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
